// File: rtl/operand_register_file_pkg.sv
// ---------------------------------------------------------------------------
// operand_register_file_pkg: shared FunSel / read-select encodings and width
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package operand_register_file_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [2:0] FUN_DEC       = 3'b000;
  localparam logic [2:0] FUN_INC       = 3'b001;
  localparam logic [2:0] FUN_LOAD      = 3'b010;
  localparam logic [2:0] FUN_CLEAR     = 3'b011;
  localparam logic [2:0] FUN_LOAD_BYTE = 3'b100;
  localparam logic [2:0] FUN_LOAD_LOW  = 3'b101;
  localparam logic [2:0] FUN_SHIFT_IN  = 3'b110;
  localparam logic [2:0] FUN_SEXT_HALF = 3'b111;

  localparam logic [1:0] SEL_R1 = 2'b00;
  localparam logic [1:0] SEL_R2 = 2'b01;
  localparam logic [1:0] SEL_R3 = 2'b10;
  localparam logic [1:0] SEL_R4 = 2'b11;

endpackage

`default_nettype wire

// File: rtl/operand_register_file_register32.sv
// ---------------------------------------------------------------------------
// register32: one general register with the eight FunSel load/count operations
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module register32
  import operand_register_file_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             E,
  input  logic [2:0]       FunSel,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] next_q;

  always_comb begin
    next_q = Q;
    case (FunSel)
      FUN_DEC:       next_q = Q - WIDTH'(1);
      FUN_INC:       next_q = Q + WIDTH'(1);
      FUN_LOAD:      next_q = I;
      FUN_CLEAR:     next_q = '0;
      FUN_LOAD_BYTE: next_q = {{(WIDTH-8){1'b0}}, I[7:0]};
      FUN_LOAD_LOW:  next_q = {Q[WIDTH-1:16], I[15:0]};
      FUN_SHIFT_IN:  next_q = {Q[WIDTH-9:0], I[7:0]};
      FUN_SEXT_HALF: next_q = {{(WIDTH-16){I[15]}}, I[15:0]};
      default:       next_q = Q;
    endcase
  end

  // Reset wins over any write presented in the same cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Q <= '0;
    end else if (E) begin
      Q <= next_q;
    end
  end

endmodule

`default_nettype wire

// File: rtl/operand_register_file.sv
// ---------------------------------------------------------------------------
// operand_register_file: four general registers R1..R4 with two async read ports
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module operand_register_file
  import operand_register_file_pkg::*;
#(
  parameter int NREG  = 4,
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] I,
  input  logic [NREG-1:0]  RegSel,
  input  logic [2:0]       FunSel,
  input  logic [1:0]       OutASel,
  input  logic [1:0]       OutBSel,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB
);

  logic [WIDTH-1:0] regs [NREG];

  // regs[0] is R1, enabled by the MSB of RegSel.
  generate
    for (genvar k = 0; k < NREG; k++) begin : g_reg
      register32 #(
        .WIDTH(WIDTH)
      ) u_reg (
        .Clock (Clock),
        .Reset (Reset),
        .E     (RegSel[NREG-1-k]),
        .FunSel(FunSel),
        .I     (I),
        .Q     (regs[k])
      );
    end
  endgenerate

  always_comb begin
    OutA = regs[0];
    case (OutASel)
      SEL_R1:  OutA = regs[0];
      SEL_R2:  OutA = regs[1];
      SEL_R3:  OutA = regs[2];
      SEL_R4:  OutA = regs[3];
      default: OutA = regs[0];
    endcase
  end

  always_comb begin
    OutB = regs[0];
    case (OutBSel)
      SEL_R1:  OutB = regs[0];
      SEL_R2:  OutB = regs[1];
      SEL_R3:  OutB = regs[2];
      SEL_R4:  OutB = regs[3];
      default: OutB = regs[0];
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_operand_register_file.sv
// ---------------------------------------------------------------------------
// tb_operand_register_file: directed vector table plus write/read timing sequences
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_operand_register_file;

  logic        Clock;
  logic        Reset;
  logic [31:0] I;
  logic [3:0]  RegSel;
  logic [2:0]  FunSel;
  logic [1:0]  OutASel;
  logic [1:0]  OutBSel;
  logic [31:0] OutA;
  logic [31:0] OutB;

  int checks;
  int failures;

  operand_register_file #(
    .NREG (4),
    .WIDTH(32)
  ) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .I      (I),
    .RegSel (RegSel),
    .FunSel (FunSel),
    .OutASel(OutASel),
    .OutBSel(OutBSel),
    .OutA   (OutA),
    .OutB   (OutB)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic        rst;
    logic [3:0]  regsel;
    logic [2:0]  funsel;
    logic [31:0] din;
    logic [1:0]  asel;
    logic [1:0]  bsel;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [3:0] rs, input logic [2:0] fs,
                       input logic [31:0] d, input logic [1:0] as, input logic [1:0] bs);
    Reset   = rst;
    RegSel  = rs;
    FunSel  = fs;
    I       = d;
    OutASel = as;
    OutBSel = bs;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //              rst  regsel   fun     din            a      b      expA           expB
    vecs[0]  = '{1'b1, 4'b0000, 3'b000, 32'h0,        2'b00, 2'b11, 32'h00000000, 32'h00000000};
    vecs[1]  = '{1'b0, 4'b1000, 3'b010, 32'h12345678, 2'b00, 2'b01, 32'h12345678, 32'h00000000};
    vecs[2]  = '{1'b0, 4'b1000, 3'b001, 32'h0,        2'b00, 2'b01, 32'h12345679, 32'h00000000};
    vecs[3]  = '{1'b0, 4'b0100, 3'b000, 32'h0,        2'b01, 2'b00, 32'hFFFFFFFF, 32'h12345679};
    vecs[4]  = '{1'b0, 4'b0100, 3'b001, 32'h0,        2'b01, 2'b00, 32'h00000000, 32'h12345679};
    vecs[5]  = '{1'b0, 4'b0010, 3'b010, 32'hAABBCCDD, 2'b10, 2'b10, 32'hAABBCCDD, 32'hAABBCCDD};
    vecs[6]  = '{1'b0, 4'b0010, 3'b101, 32'h00001122, 2'b10, 2'b10, 32'hAABB1122, 32'hAABB1122};
    vecs[7]  = '{1'b0, 4'b0010, 3'b110, 32'h000000EE, 2'b10, 2'b10, 32'hBB1122EE, 32'hBB1122EE};
    vecs[8]  = '{1'b0, 4'b0001, 3'b111, 32'h00008001, 2'b11, 2'b10, 32'hFFFF8001, 32'hBB1122EE};
    vecs[9]  = '{1'b0, 4'b0001, 3'b100, 32'h123456AB, 2'b11, 2'b10, 32'h000000AB, 32'hBB1122EE};
    vecs[10] = '{1'b0, 4'b1100, 3'b001, 32'h0,        2'b00, 2'b01, 32'h1234567A, 32'h00000001};
    vecs[11] = '{1'b0, 4'b0000, 3'b011, 32'hFFFFFFFF, 2'b00, 2'b11, 32'h1234567A, 32'h000000AB};
    vecs[12] = '{1'b1, 4'b1111, 3'b010, 32'h00000005, 2'b00, 2'b11, 32'h00000000, 32'h00000000};
    vecs[13] = '{1'b0, 4'b0000, 3'b000, 32'h0,        2'b01, 2'b10, 32'h00000000, 32'h00000000};
    vecs[14] = '{1'b0, 4'b1111, 3'b010, 32'hDEADBEEF, 2'b00, 2'b11, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[15] = '{1'b0, 4'b1111, 3'b011, 32'hDEADBEEF, 2'b00, 2'b11, 32'h00000000, 32'h00000000};
    vecs[16] = '{1'b0, 4'b0000, 3'b010, 32'h0000DEAD, 2'b01, 2'b10, 32'h00000000, 32'h00000000};
    vecs[17] = '{1'b0, 4'b0011, 3'b000, 32'h0,        2'b10, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF};

    drive(1'b0, 4'b0000, 3'b000, 32'h0, 2'b00, 2'b00);

    for (int v = 0; v < NVEC; v++) begin
      @(negedge Clock);
      drive(vecs[v].rst, vecs[v].regsel, vecs[v].funsel, vecs[v].din, vecs[v].asel, vecs[v].bsel);
      @(posedge Clock);
      #1;
      check($sformatf("vec%0d_OutA", v), OutA, vecs[v].exp_a);
      check($sformatf("vec%0d_OutB", v), OutB, vecs[v].exp_b);
    end

    // No write-through: R1 is 0 here, the load must only appear after the edge.
    @(negedge Clock);
    drive(1'b0, 4'b1000, 3'b010, 32'h12345678, 2'b00, 2'b00);
    #1;
    check("pre_edge_load_OutA", OutA, 32'h00000000);
    check("pre_edge_load_OutB", OutB, 32'h00000000);
    @(posedge Clock);
    #1;
    check("post_edge_load_OutA", OutA, 32'h12345678);
    @(negedge Clock);
    drive(1'b0, 4'b1000, 3'b001, 32'h0, 2'b00, 2'b01);
    #1;
    check("pre_edge_inc_OutA", OutA, 32'h12345678);
    @(posedge Clock);
    #1;
    check("post_edge_inc_OutA", OutA, 32'h12345679);
    check("post_edge_inc_R2", OutB, 32'h00000000);

    // Mid-sequence reset against a full load, then verify every register.
    @(negedge Clock);
    drive(1'b1, 4'b1111, 3'b010, 32'h00000005, 2'b00, 2'b01);
    @(posedge Clock);
    #1;
    check("rst_prio_R1", OutA, 32'h00000000);
    check("rst_prio_R2", OutB, 32'h00000000);
    @(negedge Clock);
    drive(1'b0, 4'b0000, 3'b010, 32'h5, 2'b10, 2'b11);
    #1;
    check("rst_prio_R3", OutA, 32'h00000000);
    check("rst_prio_R4", OutB, 32'h00000000);

    @(negedge Clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
